// File: rtl/sobel_mem_pkg.sv
// Shared types and constants for the Sobel pixel-store responder.
package sobel_mem_pkg;

  typedef enum logic [1:0] {
    INSTR_IDLE  = 2'b00,
    INSTR_READ  = 2'b01,
    INSTR_WRITE = 2'b10,
    INSTR_RSVD  = 2'b11
  } instr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR_WAIT = 2'b10
  } state_t;

  localparam int LAT_CNT_W = 4;

  // Even-parity bit: makes the XOR over data plus parity equal to zero.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sobel_mem_array.sv
// Pixel storage: one synchronous write port, one synchronous read port, no reset.
module sobel_mem_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Storage write and registered read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sobel_mem_responder.sv
// Memory-side responder for the Sobel 2-bit instruction bus, with programmable read/write latency.
// Optional feature: define MEM_PARITY_EN to store and check an even-parity bit per word.
module sobel_mem_responder
  import sobel_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        instruction,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  output logic [DATA_W-1:0] data_r,
  output logic              busy,
  output logic              rd_done,
  output logic              illegal_op,
  output logic              par_err
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      data_r_q, data_r_d;
  logic                   busy_q, busy_d;
  logic                   rd_done_q, rd_done_d;
  logic                   illegal_q, illegal_d;
  logic                   par_err_q, par_err_d;
  logic                   mem_we_s;
  logic                   par_bad_s;
  logic [ADDR_W-1:0]      rd_addr_s;
  logic [WORD_W-1:0]      mem_wdata_s;
  logic [WORD_W-1:0]      rd_word_s;

  // Read the incoming address while idle so the word is ready even at a latency of one.
  assign rd_addr_s = (state_q == IDLE) ? addr_r : addr_q;

`ifdef MEM_PARITY_EN
  assign mem_wdata_s = {even_parity(32'(data_q)), data_q};
  assign par_bad_s   = ^rd_word_s;
`else
  assign mem_wdata_s = data_q;
  assign par_bad_s   = 1'b0;
`endif

  sobel_mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .waddr_i (addr_q),
    .wdata_i (mem_wdata_s),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_word_s)
  );

  // State, counter, latches and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {LAT_CNT_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      data_r_q  <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
      illegal_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      data_r_q  <= data_r_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
      illegal_q <= illegal_d;
      par_err_q <= par_err_d;
    end
  end

  // Next-state and access sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    data_r_d  = data_r_q;
    busy_d    = busy_q;
    rd_done_d = 1'b0;
    illegal_d = illegal_q;
    par_err_d = par_err_q;
    mem_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        case (instr_t'(instruction))
          INSTR_READ: begin
            addr_d  = addr_r;
            cnt_d   = LAT_CNT_W'(RD_LAT - 1);
            busy_d  = 1'b1;
            state_d = RD_WAIT;
          end
          INSTR_WRITE: begin
            addr_d  = addr_w;
            data_d  = data_w;
            cnt_d   = LAT_CNT_W'(WR_LAT - 1);
            busy_d  = 1'b1;
            state_d = WR_WAIT;
          end
          INSTR_RSVD: illegal_d = 1'b1;
          default:    state_d   = IDLE;
        endcase
      end
      RD_WAIT: begin
        if (cnt_q != {LAT_CNT_W{1'b0}}) begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end else begin
          data_r_d  = rd_word_s[DATA_W-1:0];
          rd_done_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
          if (par_bad_s) begin
            par_err_d = 1'b1;
          end else begin
            par_err_d = par_err_q;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_q != {LAT_CNT_W{1'b0}}) begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end else begin
          mem_we_s = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_r     = data_r_q;
  assign busy       = busy_q;
  assign rd_done    = rd_done_q;
  assign illegal_op = illegal_q;
  assign par_err    = par_err_q;

endmodule

// File: tb/tb_sobel_mem_responder.sv
// Scoreboard bench for sobel_mem_responder (RD_LAT=2, WR_LAT=1); honours MEM_PARITY_EN.
module tb_sobel_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] instruction;
  logic [7:0] addr_r, addr_w, data_w;
  logic [7:0] data_r;
  logic       busy, rd_done, illegal_op, par_err;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  sobel_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .addr_r      (addr_r),
    .addr_w      (addr_w),
    .data_w      (data_w),
    .data_r      (data_r),
    .busy        (busy),
    .rd_done     (rd_done),
    .illegal_op  (illegal_op),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Read-data scoreboard: every rd_done pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (!rst && rd_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_spurious", 32'(rd_done), 32'd0);
      end else begin
        check_eq("rd_data", 32'(data_r), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one access at the current negedge and count the busy cycles that follow.
  task automatic op(input logic [1:0] ins, input logic [7:0] a, input logic [7:0] d, input int lat);
    int n;
    instruction = ins;
    addr_r = a;
    addr_w = a;
    data_w = d;
    if (ins == 2'b01) exp_q.push_back(model[a]);
    else if (ins == 2'b10) model[a] = d;
    @(negedge clk);
    instruction = 2'b00;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("latency", 32'(n), 32'(lat));
    if (ins == 2'b01) check_eq("rd_done_pulse", 32'(rd_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    instruction = 2'b00;
    addr_r = 8'h00;
    addr_w = 8'h00;
    data_w = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_data_r", 32'(data_r), 32'd0);
    check_eq("rst_rd_done", 32'(rd_done), 32'd0);
    check_eq("rst_illegal", 32'(illegal_op), 32'd0);
    check_eq("rst_par_err", 32'(par_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a pending write discards it.
    op(2'b10, 8'h05, 8'h22, 1);
    op(2'b01, 8'h05, 8'h00, 2);
    instruction = 2'b10;
    addr_w = 8'h05;
    data_w = 8'h11;
    @(posedge clk);
    #1;
    check_eq("wr_pending_busy", 32'(busy), 32'd1);
    instruction = 2'b00;
    rst = 1'b1;
    #1;
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_data_r", 32'(data_r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    op(2'b01, 8'h05, 8'h00, 2);

    // Write then read, back-to-back at the top address, and a few more patterns.
    op(2'b10, 8'h10, 8'hA5, 1);
    op(2'b01, 8'h10, 8'h00, 2);
    op(2'b10, 8'hFF, 8'h3C, 1);
    op(2'b01, 8'hFF, 8'h00, 2);
    for (int i = 0; i < 4; i++) op(2'b10, 8'(8'h40 + 8'(i * 3)), 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 4; i++) op(2'b01, 8'(8'h40 + 8'(i * 3)), 8'h00, 2);
    op(2'b10, 8'h00, 8'h5A, 1);
    op(2'b01, 8'h00, 8'h00, 2);

    // Inputs changing while busy are ignored.
    instruction = 2'b01;
    addr_r = 8'h10;
    exp_q.push_back(model[8'h10]);
    @(negedge clk);
    check_eq("hold_busy1", 32'(busy), 32'd1);
    instruction = 2'b10;
    addr_w = 8'h10;
    data_w = 8'hEE;
    addr_r = 8'h33;
    @(negedge clk);
    check_eq("hold_busy2", 32'(busy), 32'd1);
    instruction = 2'b01;
    addr_r = 8'h44;
    @(negedge clk);
    check_eq("hold_done", 32'(rd_done), 32'd1);
    instruction = 2'b00;
    op(2'b01, 8'h10, 8'h00, 2);

    // Reserved instruction sets a sticky flag and touches nothing.
    instruction = 2'b11;
    @(negedge clk);
    instruction = 2'b00;
    check_eq("rsvd_busy", 32'(busy), 32'd0);
    check_eq("rsvd_illegal", 32'(illegal_op), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("rsvd_sticky", 32'(illegal_op), 32'd1);
    op(2'b01, 8'h10, 8'h00, 2);
    op(2'b01, 8'hFF, 8'h00, 2);

`ifdef MEM_PARITY_EN
    dut.u_array.mem_q[8'h10] = dut.u_array.mem_q[8'h10] ^ 9'h001;
    model[8'h10] = model[8'h10] ^ 8'h01;
    op(2'b01, 8'h10, 8'h00, 2);
    check_eq("par_err_set", 32'(par_err), 32'd1);
`else
    op(2'b01, 8'h10, 8'h00, 2);
    check_eq("par_err_tied", 32'(par_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
